// File: rtl/ucie_ctl_sb_arbiter.sv
// Sideband message arbiter: round-robin selection among three requesters
// (LTSM, error reporter, capability advertiser), one message in flight at a
// time, with a bounded wait on the sideband TX busy handshake.
module ucie_ctl_sb_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [2:0]  i_req_vld,
    input  logic [14:0] i_req_decode,
    input  logic [95:0] i_req_cap,
    output logic [2:0]  o_req_ack,
    output logic        o_valid_lp_sb,
    output logic [4:0]  o_rdi_lp_sb_decode,
    output logic [31:0] o_rdi_lp_adv_cap_value,
    input  logic        i_pl_sb_busy,
    output logic        o_sb_timeout,
    output logic [1:0]  o_grant_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       p0, p1, p2, win;
    logic [4:0]       win_dec;
    logic [31:0]      win_cap;
    logic             in_wait, hit_limit, grant;

    assign in_wait   = (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign hit_limit = in_wait && (cnt == CNT_LAST);
    assign grant     = (state == IDLE) && (|i_req_vld) && !i_pl_sb_busy;

    // Search order starts just after the last granted requester.
    always_comb begin
        p0 = 2'd0;
        p1 = 2'd1;
        p2 = 2'd2;
        case (o_grant_id)
            2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
            2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
            default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
        endcase
    end

    // First requesting index in the rotated order, plus its payload.
    always_comb begin
        win = p2;
        if (i_req_vld[p0])      win = p0;
        else if (i_req_vld[p1]) win = p1;
        win_dec = i_req_decode[14:10];
        win_cap = i_req_cap[95:64];
        case (win)
            2'd0:    begin win_dec = i_req_decode[4:0]; win_cap = i_req_cap[31:0];  end
            2'd1:    begin win_dec = i_req_decode[9:5]; win_cap = i_req_cap[63:32]; end
            default: begin win_dec = i_req_decode[14:10]; win_cap = i_req_cap[95:64]; end
        endcase
    end

    // Next state and strobes; completion is checked before the timeout so a
    // busy drop on the last allowed cycle ends the message normally.
    always_comb begin
        state_nxt     = state;
        o_valid_lp_sb = 1'b0;
        o_req_ack     = 3'b000;
        o_sb_timeout  = 1'b0;
        case (state)
            IDLE: begin
                if (grant) state_nxt = ISSUE;
            end
            ISSUE: begin
                o_valid_lp_sb = 1'b1;
                o_req_ack     = 3'b001 << o_grant_id;
                state_nxt     = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (hit_limit) begin
                    o_sb_timeout = 1'b1;
                    state_nxt    = IDLE;
                end else if (i_pl_sb_busy) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!i_pl_sb_busy) begin
                    state_nxt = IDLE;
                end else if (hit_limit) begin
                    o_sb_timeout = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A reset cycle aborts the message: no ack, no valid, no timeout.
        if (i_rst) begin
            o_valid_lp_sb = 1'b0;
            o_req_ack     = 3'b000;
            o_sb_timeout  = 1'b0;
        end
    end

    // State register and wait counter (cleared on issue, counts while waiting).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ISSUE)  cnt <= '0;
            else if (in_wait)    cnt <= cnt + 1'b1;
        end
    end

    // Capture the winner and its payload on the grant; held until the next one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_grant_id             <= 2'd2;
            o_rdi_lp_sb_decode     <= '0;
            o_rdi_lp_adv_cap_value <= '0;
        end else if (grant) begin
            o_grant_id             <= win;
            o_rdi_lp_sb_decode     <= win_dec;
            o_rdi_lp_adv_cap_value <= win_cap;
        end
    end

endmodule

// File: tb/tb_ucie_ctl_sb_arbiter.sv
// Bench for ucie_ctl_sb_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle by a message-level model.
module tb_ucie_ctl_sb_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [14:0] dec = '0;
    logic [95:0] cap = '0;
    logic        busy = 1'b0;
    logic [2:0]  ack;
    logic        valid, tmo;
    logic [4:0]  o_dec;
    logic [31:0] o_cap;
    logic [1:0]  gid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ucie_ctl_sb_arbiter #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_vld(req), .i_req_decode(dec),
        .i_req_cap(cap), .o_req_ack(ack), .o_valid_lp_sb(valid),
        .o_rdi_lp_sb_decode(o_dec), .o_rdi_lp_adv_cap_value(o_cap),
        .i_pl_sb_busy(busy), .o_sb_timeout(tmo), .o_grant_id(gid)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks a message as: issued this cycle, or waiting for age cycles,
    // having seen busy or not.
    bit          m_ok = 0, m_issue = 0, m_act = 0, m_seen = 0;
    int          m_age = 0, m_g = 2;
    logic [4:0]  m_dec = '0;
    logic [31:0] m_cap = '0;

    always @(negedge clk) begin
        bit e_valid, e_to, found;
        int c;
        e_valid = !rst && m_issue;
        e_to    = !rst && m_act && (m_age == TO) && !(m_seen && !busy);
        if (m_ok) begin
            chk("valid", valid, e_valid);
            chk("ack", ack, e_valid ? (32'd1 << m_g) : 32'd0);
            chk("timeout", tmo, e_to);
            chk("grant_id", gid, m_g);
            chk("decode", o_dec, m_dec);
            chk("cap", o_cap, m_cap);
        end
        if (rst) begin
            m_ok = 1; m_issue = 0; m_act = 0; m_g = 2; m_dec = '0; m_cap = '0;
        end else if (m_issue) begin
            m_issue = 0; m_act = 1; m_age = 1; m_seen = 0;
        end else if (m_act) begin
            if ((m_seen && !busy) || e_to) m_act = 0;
            else begin
                if (busy) m_seen = 1;
                m_age++;
            end
        end else if (|req && !busy) begin
            found = 0;
            for (int i = 1; i <= 3; i++) begin
                c = (m_g + i) % 3;
                if (!found && req[c]) begin
                    found = 1;
                    m_g = c;
                    m_dec = dec[5*c +: 5];
                    m_cap = cap[32*c +: 32];
                end
            end
            m_issue = 1;
        end
    end

    // ---------------- stimulus ----------------
    bit          n_rst = 1, force_busy = 0, noise = 0, rand_resp = 0;
    logic [2:0]  n_req = '0;
    logic [4:0]  n_dec [3] = '{default: '0};
    logic [31:0] n_cap [3] = '{default: '0};
    // Sideband responder: busy high for cycles D..D+L-1 after valid; D=0 never.
    bit          r_msg = 0;
    int          r_k = 0, r_D = 1, r_L = 3;
    bit          obs_valid, obs_to;
    logic [2:0]  obs_ack;
    logic [1:0]  obs_gid;

    task automatic cyc();
        bit mb;
        @(posedge clk); #1;
        rst = n_rst;
        req = n_req;
        dec = {n_dec[2], n_dec[1], n_dec[0]};
        cap = {n_cap[2], n_cap[1], n_cap[0]};
        if (n_rst) r_msg = 0;
        if (r_msg) r_k++;
        mb = r_msg && (r_D != 0) && (r_k >= r_D) && (r_k < r_D + r_L);
        if (r_msg && ((r_D != 0 && r_k >= r_D + r_L) || r_k > 2 * TO)) r_msg = 0;
        busy = force_busy | mb | (noise && !r_msg && ($urandom % 4 == 0));
        @(negedge clk);
        obs_valid = valid; obs_to = tmo; obs_ack = ack; obs_gid = gid;
        if (obs_valid) begin
            r_msg = 1; r_k = 0;
            if (rand_resp) begin
                r_D = ($urandom % 6 == 0) ? 0 : $urandom_range(1, 3);
                r_L = $urandom_range(1, 9);
            end
        end
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        do begin cyc(); n++; end while (!obs_valid && n < 20);
        chk(nm, obs_valid, 1);
    endtask

    task automatic count_to_timeout(input string nm, input int exp);
        int j = 0;
        do begin cyc(); j++; end while (!obs_to && j < 20);
        chk(nm, j, exp);
    endtask

    initial begin
        int got[$];
        int ord[4] = '{0, 1, 2, 0};
        int nv;

        repeat (3) cyc();
        chk("rst_grant_id", gid, 2);
        chk("rst_valid", valid, 0);
        chk("rst_decode", o_dec, 0);
        chk("rst_cap", o_cap, 0);
        n_rst = 0;

        // Scenario 1: all three requesting, busy 1 cycle after valid for 3 cycles.
        for (int b = 0; b < 3; b++) begin n_dec[b] = 5'(b + 1); n_cap[b] = 32'h100 + b; end
        n_req = 3'b111;
        for (int c = 0; c < 60 && got.size() < 4; c++) begin
            cyc();
            if (obs_valid) begin
                chk("s1_ack", obs_ack, 32'd1 << ord[got.size()]);
                got.push_back(obs_gid);
            end
        end
        chk("s1_grants", got.size(), 4);
        for (int i = 0; i < got.size(); i++) chk("s1_order", got[i], ord[i]);
        n_req = '0;
        repeat (12) cyc();

        // Scenario 2: payload of requester 1.
        n_dec[1] = 5'h0A; n_cap[1] = 32'hDEADBEEF; n_req = 3'b010;
        wait_valid("s2_issue");
        chk("s2_ack", obs_ack, 3'b010);
        chk("s2_decode", o_dec, 5'h0A);
        chk("s2_cap", o_cap, 32'hDEADBEEF);
        n_req = '0;
        repeat (12) cyc();

        // Scenario 3: busy held in IDLE blocks the grant.
        force_busy = 1; n_req = 3'b001; nv = 0;
        repeat (6) begin cyc(); nv += int'(obs_valid); end
        chk("s3_no_grant_busy", nv, 0);
        force_busy = 0;
        cyc(); chk("s3_not_same_cycle", obs_valid, 0);
        cyc(); chk("s3_grant_next", obs_valid, 1);
        chk("s3_gid", obs_gid, 0);
        n_req = '0;
        repeat (12) cyc();

        // Scenario 4: busy never asserts.
        r_D = 0; n_req = 3'b100;
        wait_valid("s4_issue");
        n_req = '0;
        count_to_timeout("s4_timeout_delay", TO);
        r_D = 1; r_L = 3; n_req = 3'b001;
        cyc(); chk("s4_idle_after", obs_valid, 0);
        cyc(); chk("s4_regrant", obs_valid, 1);
        n_req = '0;
        repeat (12) cyc();

        // Scenario 5: busy falls on the last allowed wait cycle -> no timeout.
        r_D = 1; r_L = 7; n_req = 3'b010;
        wait_valid("s5_issue");
        n_req = '0; nv = 0;
        repeat (12) begin cyc(); nv += int'(obs_to); end
        chk("s5_no_timeout", nv, 0);
        // One cycle later is too late.
        r_L = 8; n_req = 3'b001;
        wait_valid("s5b_issue");
        n_req = '0;
        count_to_timeout("s5b_timeout_delay", TO);
        repeat (12) cyc();

        // Scenario 6: reset during WAIT_DONE.
        r_D = 1; r_L = 6; n_req = 3'b010;
        wait_valid("s6_issue");
        n_req = '0;
        repeat (3) cyc();
        n_rst = 1; n_req = 3'b001;
        cyc();
        chk("s6_rst_no_ack", obs_ack, 0);
        chk("s6_rst_no_to", obs_to, 0);
        n_rst = 0;
        cyc();
        chk("s6_gid", obs_gid, 2);
        chk("s6_valid", obs_valid, 0);
        chk("s6_decode", o_dec, 0);
        chk("s6_cap", o_cap, 0);
        cyc();
        chk("s6_regrant", obs_valid, 1);
        chk("s6_regrant_gid", obs_gid, 0);
        n_req = '0;
        repeat (12) cyc();

        // Randomized traffic.
        rand_resp = 1; noise = 1;
        repeat (3000) begin
            cyc();
            n_rst = ($urandom % 300 == 0);
            for (int b = 0; b < 3; b++) begin
                if (obs_ack[b] && ($urandom % 2 == 0)) n_req[b] = 1'b0;
                else if (!n_req[b] && ($urandom % 4 == 0)) begin
                    n_req[b] = 1'b1;
                    n_dec[b] = 5'($urandom);
                    n_cap[b] = $urandom;
                end else if (n_req[b] && ($urandom % 32 == 0)) n_req[b] = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
